// File: rtl/cpu_ram_mirror.sv
// cpu_ram_mirror: single-port CPU work RAM decoded into an address window
// and mirrored across it. After reset an optional sequencer writes INIT_VAL
// into every location. Reads have one cycle of latency and are flagged by
// rvalid. A read and a write to the same address in the same cycle return
// the new write data. A read that misses the window leaves out unchanged,
// so the bus keeps its last value.
//
// Ports:
//   CLK      in   system clock, rising edge
//   Reset    in   asynchronous active-high reset
//   w        in   write request
//   r        in   read request
//   address  in   [ADDR_W-1:0] CPU byte address
//   in       in   [DATA_W-1:0] write data
//   out      out  [DATA_W-1:0] registered read data
//   rvalid   out  out was updated by a read accepted the previous cycle
//   hit      out  combinational window decode of address
//   busy     out  clear sequencer running; requests are ignored
module cpu_ram_mirror #(
  parameter int unsigned       DATA_W         = 8,
  parameter int unsigned       ADDR_W         = 16,
  parameter int unsigned       MEM_AW         = 11,
  parameter int unsigned       WINDOW_AW      = 13,
  parameter logic [ADDR_W-1:0] BASE           = '0,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VAL       = '0
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              w,
  input  logic              r,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out,
  output logic              rvalid,
  output logic              hit,
  output logic              busy
);

  localparam int unsigned DEPTH = 1 << MEM_AW;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Reject window geometries that cannot mirror the RAM
  if (MEM_AW > WINDOW_AW || WINDOW_AW > ADDR_W) begin : g_bad_geometry
    $error("cpu_ram_mirror: require MEM_AW <= WINDOW_AW <= ADDR_W");
  end

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [MEM_AW-1:0] r_cnt;
  logic [MEM_AW-1:0] w_idx;
  logic              w_we;
  logic              w_rd;
  logic [MEM_AW-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_out;
  logic              r_rvalid;
  logic              r_busy;
  logic              w_unused_addr;

  // Bits between MEM_AW and WINDOW_AW select a mirror and are dropped
  assign w_idx         = address[MEM_AW-1:0];
  assign w_unused_addr = ^address;

  // Window decode; a window covering the whole address space always hits
  if (WINDOW_AW < ADDR_W) begin : g_hit_cmp
    assign hit = (address[ADDR_W-1:WINDOW_AW] == BASE[ADDR_W-1:WINDOW_AW]);
  end else begin : g_hit_all
    assign hit = 1'b1;
  end

  // State register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and the RAM write port: the clear sequencer owns the port in CLEAR
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_rd        = 1'b0;
    w_waddr     = w_idx;
    w_wdata     = in;
    case (r_state)
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
        w_wdata = INIT_VAL;
        if (r_cnt == '1) begin
          w_state_nxt = ST_READY;
        end
      end
      default: begin
        w_we = w & hit;
        w_rd = r;
      end
    endcase
  end

  // Clear address counter
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_cnt <= r_cnt + MEM_AW'(1);
    end
  end

  // RAM array; contents survive reset
  always_ff @(posedge CLK) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Read data, strobe and busy flag
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_out    <= '0;
      r_rvalid <= 1'b0;
      r_busy   <= CLEAR_ON_RESET;
    end else begin
      r_busy   <= (w_state_nxt == ST_CLEAR);
      r_rvalid <= w_rd;
      // Write-first on collision; a miss leaves the last bus value in place
      if (w_rd && hit) begin
        r_out <= w ? in : r_mem[w_idx];
      end
    end
  end

  assign out    = r_out;
  assign rvalid = r_rvalid;
  assign busy   = r_busy;

endmodule

// File: tb/tb_cpu_ram_mirror.sv
// Directed bench for cpu_ram_mirror: default 2 KB instance with clear value
// A5, plus a 4 KB instance windowed at 0x6000 with no clear sequencer.
module tb_cpu_ram_mirror;

  logic        clk;
  logic        rst_a, a_w, a_r, a_rvalid, a_hit, a_busy;
  logic [15:0] a_addr;
  logic [7:0]  a_in, a_out;
  logic        rst_b, b_w, b_r, b_rvalid, b_hit, b_busy;
  logic [15:0] b_addr;
  logic [7:0]  b_in, b_out;

  int n_vec = 0;
  int n_err = 0;

  cpu_ram_mirror #(
    .DATA_W(8), .ADDR_W(16), .MEM_AW(11), .WINDOW_AW(13),
    .BASE(16'h0000), .CLEAR_ON_RESET(1'b1), .INIT_VAL(8'hA5)
  ) u_dut_a (
    .CLK(clk), .Reset(rst_a), .w(a_w), .r(a_r), .address(a_addr), .in(a_in),
    .out(a_out), .rvalid(a_rvalid), .hit(a_hit), .busy(a_busy)
  );

  cpu_ram_mirror #(
    .DATA_W(8), .ADDR_W(16), .MEM_AW(12), .WINDOW_AW(13),
    .BASE(16'h6000), .CLEAR_ON_RESET(1'b0), .INIT_VAL(8'h00)
  ) u_dut_b (
    .CLK(clk), .Reset(rst_b), .w(b_w), .r(b_r), .address(b_addr), .in(b_in),
    .out(b_out), .rvalid(b_rvalid), .hit(b_hit), .busy(b_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic a_rd(input logic [15:0] addr, input logic [7:0] exp, input string tag);
    a_addr = addr;
    a_r    = 1'b1;
    a_w    = 1'b0;
    @(negedge clk);
    a_r = 1'b0;
    chk({tag, "_rvalid"}, 32'(a_rvalid), 32'd1);
    chk(tag, 32'(a_out), 32'(exp));
  endtask

  task automatic a_wr(input logic [15:0] addr, input logic [7:0] data);
    a_addr = addr;
    a_in   = data;
    a_w    = 1'b1;
    a_r    = 1'b0;
    @(negedge clk);
    a_w = 1'b0;
  endtask

  // Count sampled busy cycles from now until busy drops (bounded)
  task automatic count_clear(output int n, output int rv);
    n  = 0;
    rv = 0;
    while (a_busy === 1'b1 && n < 5000) begin
      if (a_rvalid !== 1'b0) rv++;
      n++;
      @(negedge clk);
    end
  endtask

  int n_busy, n_rv;

  initial begin
    clk   = 1'b0;
    rst_a = 1'b1; a_w = 1'b0; a_r = 1'b0; a_addr = '0; a_in = '0;
    rst_b = 1'b1; b_w = 1'b0; b_r = 1'b0; b_addr = '0; b_in = '0;
    @(negedge clk);
    @(negedge clk);

    chk("rst_busy",   32'(a_busy),   32'd1);
    chk("rst_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_out",    32'(a_out),    32'h0);
    chk("b_rst_busy", 32'(b_busy),   32'd0);

    // Windowed instance: no clear, base 0x6000, 4 KB mirrored twice
    rst_b = 1'b0;
    @(negedge clk);
    chk("b_busy_ready", 32'(b_busy), 32'd0);
    b_addr = 16'h6123; b_in = 8'h5A; b_w = 1'b1;
    @(negedge clk);
    b_w = 1'b0; b_addr = 16'h7123; b_r = 1'b1;
    @(negedge clk);
    b_r = 1'b0;
    chk("b_mirror_rvalid", 32'(b_rvalid), 32'd1);
    chk("b_mirror_out",    32'(b_out),    32'h5A);
    b_addr = 16'h0123; #1;
    chk("b_hit_0123", 32'(b_hit), 32'd0);
    b_addr = 16'h7FFF; #1;
    chk("b_hit_7fff", 32'(b_hit), 32'd1);
    b_addr = 16'h8123; #1;
    chk("b_hit_8123", 32'(b_hit), 32'd0);

    // Main instance: clear sequencer length
    @(negedge clk);
    rst_a = 1'b0;
    count_clear(n_busy, n_rv);
    chk("clear_len",    32'(n_busy), 32'd2048);
    chk("clear_rvalid", 32'(n_rv),   32'd0);
    chk("clear_out",    32'(a_out),  32'h0);

    a_rd(16'h07FF, 8'hA5, "rd_07ff");
    @(negedge clk);
    chk("idle_rvalid", 32'(a_rvalid), 32'd0);
    chk("idle_hold",   32'(a_out),    32'hA5);

    // Mirroring, back-to-back reads
    a_wr(16'h0012, 8'h3C);
    chk("wr_rvalid", 32'(a_rvalid), 32'd0);
    a_rd(16'h0812, 8'h3C, "rd_0812");
    a_rd(16'h1012, 8'h3C, "rd_1012");
    a_rd(16'h1812, 8'h3C, "rd_1812");

    // Window miss: read holds the bus, write is dropped
    a_addr = 16'h1FFF; #1;
    chk("hit_1fff", 32'(a_hit), 32'd1);
    a_addr = 16'h2012; #1;
    chk("hit_2012", 32'(a_hit), 32'd0);
    a_rd(16'h0012, 8'h3C, "rd_0012");
    a_rd(16'h2012, 8'h3C, "rd_miss_hold");
    a_wr(16'h2012, 8'hFF);
    a_rd(16'h0012, 8'h3C, "rd_after_miss_wr");

    // Same-cycle read and write: new data wins
    a_addr = 16'h0040; a_in = 8'h77; a_w = 1'b1; a_r = 1'b1;
    @(negedge clk);
    a_w = 1'b0; a_r = 1'b0;
    chk("rw_rvalid", 32'(a_rvalid), 32'd1);
    chk("rw_out",    32'(a_out),    32'h77);
    @(negedge clk);
    a_rd(16'h0040, 8'h77, "rd_0040");
    a_rd(16'h0041, 8'hA5, "rd_0041");

    // Reset in the middle of a clear restarts it from location 0
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid_busy", 32'(a_busy), 32'd1);
    rst_a = 1'b1;
    @(negedge clk);
    chk("mid_rst_out", 32'(a_out), 32'h0);
    a_addr = 16'h0040; a_in = 8'h11; a_w = 1'b1; a_r = 1'b1;
    rst_a = 1'b0;
    count_clear(n_busy, n_rv);
    a_w = 1'b0; a_r = 1'b0;
    chk("reclear_len",    32'(n_busy), 32'd2048);
    chk("reclear_rvalid", 32'(n_rv),   32'd0);
    a_rd(16'h0040, 8'hA5, "rd_0040_cleared");
    a_rd(16'h0012, 8'hA5, "rd_0012_cleared");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_ram_mirror.md
Name: cpu_ram_mirror

Overview:
Parametrised successor to the CPU work-RAM block: a synchronous single-port RAM decoded into a configurable address window and mirrored across it. Adds a hardware clear sequencer after reset (no file preload), a read-valid strobe, write-first read/write collision handling, and open-bus hold on window misses. Sits on the CPU data bus beside the PPU/APU register decoders; the bus mux uses out/rvalid/hit.

Parameters:
DATA_W, 8, data bus width in bits
ADDR_W, 16, CPU address width
MEM_AW, 11, physical RAM address width (depth = 2**MEM_AW; 11 = 2 KB)
WINDOW_AW, 13, window size exponent; mirrors = 2**(WINDOW_AW-MEM_AW); legal only if MEM_AW <= WINDOW_AW <= ADDR_W
BASE, 16'h0000, window base; only bits [ADDR_W-1:WINDOW_AW] are compared
CLEAR_ON_RESET, 1, 1 = run clear sequencer after reset, 0 = READY immediately
INIT_VAL, 8'h00, value written to every location during clear

Ports:
CLK  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-high reset
w  input  1  write request, sampled at posedge
r  input  1  read request, sampled at posedge
address  input  ADDR_W  CPU byte address
in  input  DATA_W  write data
out  output  DATA_W  read data, registered
rvalid  output  1  one-cycle strobe: out updated by a read accepted the previous cycle
hit  output  1  combinational: address[ADDR_W-1:WINDOW_AW] == BASE[ADDR_W-1:WINDOW_AW]
busy  output  1  high while clear sequencer runs; requests ignored

Behaviour:
- Interface: one clock CLK; Reset is asynchronous and active-high.
- Reset (async assert, any state): out=0, rvalid=0, clear counter=0, busy=1 if CLEAR_ON_RESET else 0. State = CLEAR if CLEAR_ON_RESET else READY. RAM contents are not reset asynchronously.
- States: CLEAR, READY.
- CLEAR: each cycle write INIT_VAL to ram[cnt], cnt++; after location 2**MEM_AW-1 is written, go to READY next edge. Takes exactly 2**MEM_AW cycles from first edge after Reset deasserts. busy=1 throughout; w/r ignored, rvalid stays 0, out holds 0.
- Reset asserted mid-CLEAR: counter returns to 0; full clear reruns.
- READY: busy=0; stays READY until Reset.
- Physical index = address[MEM_AW-1:0]; bits [WINDOW_AW-1:MEM_AW] ignored (mirroring).
- Write: w & hit in READY -> ram[index] <= in at that edge. w & ~hit -> no write.
- Read: r in READY at edge N -> at edge N (visible cycle N+1) rvalid=1 for one cycle; if hit, out = ram[index]; if ~hit, out holds previous value (open bus). Latency 1 cycle.
- r & w & hit same edge: write-first, out = in. r and w always share one address (single port).
- r=0: rvalid=0 next cycle; out holds.
- Back-to-back reads each cycle: rvalid stays high, out updates every cycle.
- hit purely combinational from address, valid in all states.

Test Plan:
- Reset, CLEAR_ON_RESET=1, INIT_VAL=8'hA5: busy high exactly 2048 cycles, then 0; read 0x07FF -> next cycle out=A5, rvalid=1.
- Write 0x0012=8'h3C, read 0x0812, 0x1012, 0x1812 -> each returns 3C with rvalid 1 cycle after request (mirroring).
- Read 0x0012 (3C) then read 0x2012 -> hit=0, rvalid=1, out stays 3C; then write 0x2012=FF, read 0x0012 -> 3C (miss write dropped).
- Same edge r=1,w=1,address=0x0040,in=8'h77 -> next cycle out=77, rvalid=1; later read 0x0040 -> 77.
- Assert Reset at clear count 100, release -> busy high another full 2048 cycles; w/r during CLEAR -> rvalid 0, no RAM change.
- BASE=16'h6000, WINDOW_AW=13, MEM_AW=12: write 0x6123=5A, read 0x7123 -> 5A; address 0x0123 -> hit=0.
